// File: rtl/flappy_bird_overlay_if.sv
// rtl/flappy_bird_overlay_if.sv - video bus between sync generator/background source and the bird overlay
interface flappy_bird_overlay_if;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       hsync_in;
  logic       vsync_in;
  logic [2:0] bg_rgb;
  logic [2:0] rgb;
  logic       hsync;
  logic       vsync;

  modport master (
    output hpos, vpos, display_on, hsync_in, vsync_in, bg_rgb,
    input  rgb, hsync, vsync
  );

  modport slave (
    input  hpos, vpos, display_on, hsync_in, vsync_in, bg_rgb,
    output rgb, hsync, vsync
  );
endinterface

// File: rtl/flappy_bird_overlay.sv
// rtl/flappy_bird_overlay.sv - bird sprite, flap/gravity physics, mountain collision and score over the background
// Optional score bar along the top rows is built when FLAPPY_SCORE_BAR_EN is defined.
module flappy_bird_overlay #(
  parameter int         BIRD_X      = 64,
  parameter int         START_Y     = 120,
  parameter int         FLOOR_Y     = 232,
  parameter int         CEIL_Y      = 8,
  parameter int         FLAP_V      = 6,
  parameter int         MAX_FALL    = 8,
  parameter logic [2:0] BIRD_COLOR  = 3'b110,
  parameter logic [2:0] DEAD_COLOR  = 3'b100,
  parameter int         DEAD_FRAMES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  flappy_bird_overlay_if.slave        vid,
  input  logic                        flap,
  output logic [7:0]                  score,
  output logic                        alive
);
  typedef enum logic [1:0] {IDLE, FLY, DEAD} state_t;

  localparam logic [63:0]       BITMAP   = 64'h183C7EFFFFF77E3C;
  localparam logic signed [5:0] VEL_FLAP = 6'(-FLAP_V);
  localparam logic signed [5:0] VEL_MAX  = 6'(MAX_FALL);

  state_t            state, state_nx;
  logic [9:0]        bird_y, bird_y_nx;
  logic signed [5:0] vel, vel_nx, vel_step;
  logic [7:0]        score_nx;
  logic [4:0]        frame_cnt, frame_cnt_nx;
  logic [6:0]        dead_cnt, dead_cnt_nx;
  logic              hit, hit_nx;
  logic              flap_pending, flap_pending_nx;
  logic              sync1, sync2, sync3;
  logic [2:0]        rgb_q, rgb_nx;
  logic              hsync_q, vsync_q;

  logic              tick, flap_edge, flap_block, sprite_px;
  logic [9:0]        dx, dy, y_clamped;
  logic signed [10:0] y_sum;

  assign tick       = (vid.hpos == 10'd0) && (vid.vpos == 10'd0);
  assign flap_edge  = sync2 & ~sync3;
  assign flap_block = (state == DEAD) && (dead_cnt < 7'(DEAD_FRAMES));
  assign dx         = vid.hpos - 10'(BIRD_X);
  assign dy         = vid.vpos - bird_y;
  assign sprite_px  = (dx < 10'd8) && (dy < 10'd8) && BITMAP[{dy[2:0], dx[2:0]}];

  // Shared by the IDLE launch and every FLY tick; pending flap overrides gravity.
  always_comb begin
    vel_step  = flap_pending ? VEL_FLAP : ((vel >= VEL_MAX) ? VEL_MAX : vel + 6'sd1);
    y_sum     = $signed({1'b0, bird_y}) + $signed({{5{vel_step[5]}}, vel_step});
    y_clamped = (y_sum < $signed(11'(CEIL_Y))) ? 10'(CEIL_Y) : y_sum[9:0];
  end

  always_comb begin
    state_nx        = state;
    bird_y_nx       = bird_y;
    vel_nx          = vel;
    score_nx        = score;
    frame_cnt_nx    = frame_cnt;
    dead_cnt_nx     = dead_cnt;
    flap_pending_nx = flap_pending | (flap_edge & ~flap_block);
    hit_nx          = hit | ((state == FLY) && sprite_px && vid.display_on && vid.bg_rgb[1]);
    if (tick) begin
      flap_pending_nx = flap_edge & ~flap_block;
      hit_nx          = 1'b0;
      case (state)
        IDLE: begin
          bird_y_nx = 10'(START_Y);
          vel_nx    = '0;
          if (flap_pending) begin
            state_nx     = FLY;
            vel_nx       = VEL_FLAP;
            bird_y_nx    = y_clamped;
            score_nx     = '0;
            frame_cnt_nx = '0;
          end
        end
        FLY: begin
          vel_nx    = vel_step;
          bird_y_nx = y_clamped;
          if (hit || (y_clamped >= 10'(FLOOR_Y))) begin
            state_nx    = DEAD;
            dead_cnt_nx = '0;
          end else begin
            frame_cnt_nx = frame_cnt + 5'd1;
            if ((frame_cnt == 5'd31) && (score != 8'hFF)) score_nx = score + 8'd1;
          end
        end
        DEAD: begin
          if (flap_block) dead_cnt_nx = dead_cnt + 7'd1;
          else if (flap_pending) begin
            state_nx  = IDLE;
            bird_y_nx = 10'(START_Y);
            vel_nx    = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    rgb_nx = 3'b000;
    if (vid.display_on) begin
      if (sprite_px) rgb_nx = (state == DEAD) ? DEAD_COLOR : BIRD_COLOR;
      else           rgb_nx = vid.bg_rgb;
`ifdef FLAPPY_SCORE_BAR_EN
      if ((vid.vpos < 10'd4) && (vid.hpos < {1'b0, score, 1'b0})) rgb_nx = 3'b111;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      bird_y       <= 10'(START_Y);
      vel          <= '0;
      score        <= '0;
      frame_cnt    <= '0;
      dead_cnt     <= '0;
      hit          <= 1'b0;
      flap_pending <= 1'b0;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync3        <= 1'b0;
      rgb_q        <= 3'b000;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
    end else begin
      state        <= state_nx;
      bird_y       <= bird_y_nx;
      vel          <= vel_nx;
      score        <= score_nx;
      frame_cnt    <= frame_cnt_nx;
      dead_cnt     <= dead_cnt_nx;
      hit          <= hit_nx;
      flap_pending <= flap_pending_nx;
      sync1        <= flap;
      sync2        <= sync1;
      sync3        <= sync2;
      rgb_q        <= rgb_nx;
      hsync_q      <= vid.hsync_in;
      vsync_q      <= vid.vsync_in;
    end
  end

  assign vid.rgb   = rgb_q;
  assign vid.hsync = hsync_q;
  assign vid.vsync = vsync_q;
  assign alive     = (state == FLY);
endmodule

// File: tb/tb_flappy_bird_overlay.sv
// tb/tb_flappy_bird_overlay.sv - directed self-checking bench for flappy_bird_overlay
module tb_flappy_bird_overlay;
  logic       clk = 1'b0;
  logic       reset;
  logic       flap;
  logic [7:0] score;
  logic       alive;
  logic [2:0] px;
  int         checks = 0;
  int         errors = 0;

  flappy_bird_overlay_if vif ();

  flappy_bird_overlay dut (
    .clk   (clk),
    .reset (reset),
    .vid   (vif.slave),
    .flap  (flap),
    .score (score),
    .alive (alive)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    vif.hpos = 10'd1; vif.vpos = 10'd0; vif.display_on = 1'b0; vif.bg_rgb = 3'b000;
  endtask

  task automatic do_tick();
    vif.hpos = 10'd0; vif.vpos = 10'd0; vif.display_on = 1'b0; vif.bg_rgb = 3'b000;
    step();
    idle_bus();
    step();
  endtask

  task automatic pulse_flap();
    idle_bus();
    flap = 1'b1;
    step(); step();
    flap = 1'b0;
    repeat (4) step();
  endtask

  task automatic probe(input int x, input int y, input logic [2:0] bg, input logic disp, output logic [2:0] got);
    vif.hpos = 10'(x); vif.vpos = 10'(y); vif.bg_rgb = bg; vif.display_on = disp;
    step();
    got = vif.rgb;
    idle_bus();
  endtask

  initial begin
    reset = 1'b0; flap = 1'b0;
    vif.hpos = 10'd0; vif.vpos = 10'd0; vif.display_on = 1'b1; vif.bg_rgb = 3'b111;
    vif.hsync_in = 1'b1; vif.vsync_in = 1'b1;
    repeat (3) step();
    check("rst_rgb", vif.rgb, 3'd0);
    check("rst_hsync", vif.hsync, 1'b0);
    check("rst_vsync", vif.vsync, 1'b0);
    check("rst_alive", alive, 1'b0);
    check("rst_score", score, 8'd0);
    check("rst_bird_y", dut.bird_y, 10'd120);
    reset = 1'b1;
    idle_bus();
    vif.hsync_in = 1'b1; vif.vsync_in = 1'b0;
    step();
    check("hsync_dly_hi", vif.hsync, 1'b1);
    check("vsync_dly_lo", vif.vsync, 1'b0);
    vif.hsync_in = 1'b0; vif.vsync_in = 1'b1;
    step();
    check("hsync_dly_lo", vif.hsync, 1'b0);
    check("vsync_dly_hi", vif.vsync, 1'b1);

    // IDLE sprite placement at column 64, rows 120..127
    probe(66, 120, 3'b001, 1'b1, px); check("spr_66_120", px, 3'b110);
    probe(64, 120, 3'b001, 1'b1, px); check("spr_64_120_clear", px, 3'b001);
    probe(64, 123, 3'b001, 1'b1, px); check("spr_64_123", px, 3'b110);
    probe(63, 123, 3'b001, 1'b1, px); check("spr_63_left", px, 3'b001);
    probe(72, 123, 3'b001, 1'b1, px); check("spr_72_right", px, 3'b001);
    probe(67, 127, 3'b001, 1'b1, px); check("spr_67_127", px, 3'b110);
    probe(64, 128, 3'b001, 1'b1, px); check("spr_row_below", px, 3'b001);
    probe(66, 120, 3'b011, 1'b0, px); check("spr_blank", px, 3'b000);

    // launch and free-fall trajectory to the floor
    pulse_flap();
    do_tick();
    check("launch_alive", alive, 1'b1);
    check("launch_y", dut.bird_y, 10'd114);
    do_tick(); check("fall_y1", dut.bird_y, 10'd109);
    do_tick(); check("fall_y2", dut.bird_y, 10'd105);
    do_tick(); check("fall_y3", dut.bird_y, 10'd102);
    do_tick(); check("fall_y4", dut.bird_y, 10'd100);
    do_tick(); check("fall_y5", dut.bird_y, 10'd99);
    repeat (9) do_tick();
    check("fall_y14", dut.bird_y, 10'd135);
    do_tick(); check("fall_y15", dut.bird_y, 10'd143);
    repeat (11) do_tick();
    check("fall_y26", dut.bird_y, 10'd231);
    check("fall_alive26", alive, 1'b1);
    do_tick();
    check("floor_y", dut.bird_y, 10'd239);
    check("floor_dead", alive, 1'b0);
    probe(64, 242, 3'b001, 1'b1, px); check("dead_color", px, 3'b100);
    check("floor_score", score, 8'd0);

    // DEAD lockout: flaps up to dead_cnt 63 are discarded
    pulse_flap(); do_tick();
    probe(66, 120, 3'b001, 1'b1, px); check("dead_flap_ignored", px, 3'b001);
    repeat (62) do_tick();
    pulse_flap(); do_tick();
    probe(66, 120, 3'b001, 1'b1, px); check("dead_flap_63_ignored", px, 3'b001);
    probe(64, 242, 3'b001, 1'b1, px); check("dead_frozen", px, 3'b100);
    pulse_flap(); do_tick();
    probe(66, 120, 3'b001, 1'b1, px); check("dead_to_idle", px, 3'b110);
    check("idle_alive", alive, 1'b0);

    // two flap edges between ticks apply once
    pulse_flap(); pulse_flap();
    do_tick(); check("dbl_y_launch", dut.bird_y, 10'd114);
    do_tick(); check("dbl_y_next", dut.bird_y, 10'd109);

    // flap edge 2 cycles before a tick lands on the following tick
    idle_bus();
    flap = 1'b1;
    step();
    vif.hpos = 10'd0; vif.vpos = 10'd0;
    step();
    idle_bus();
    flap = 1'b0;
    step(); step();
    check("late_flap_y", dut.bird_y, 10'd105);
    do_tick(); check("late_flap_applied", dut.bird_y, 10'd99);

    // collisions: bit 1 kills, star colour does not
    probe(64, 102, 3'b101, 1'b1, px); check("star_opaque", px, 3'b110);
    do_tick();
    check("star_alive", alive, 1'b1);
    check("star_y", dut.bird_y, 10'd94);
    probe(64, 97, 3'b010, 1'b1, px); check("mtn_opaque", px, 3'b110);
    pulse_flap();
    do_tick();
    check("mtn_dead_despite_flap", alive, 1'b0);

    // mid-operation reset, then long flight for scoring
    reset = 1'b0; vif.hsync_in = 1'b1;
    step();
    check("mid_rst_alive", alive, 1'b0);
    check("mid_rst_hsync", vif.hsync, 1'b0);
    check("mid_rst_y", dut.bird_y, 10'd120);
    reset = 1'b1; vif.hsync_in = 1'b0;
    pulse_flap();
    do_tick();
    for (int i = 1; i <= 8192; i++) begin
      if (i % 13 == 0) pulse_flap();
      do_tick();
      if (i == 320) begin
        check("score_10", score, 8'd10);
`ifdef FLAPPY_SCORE_BAR_EN
        probe(19, 2, 3'b001, 1'b1, px); check("bar_hpos19", px, 3'b111);
        probe(20, 2, 3'b001, 1'b1, px); check("bar_hpos20", px, 3'b001);
`else
        probe(5, 2, 3'b001, 1'b1, px); check("no_bar", px, 3'b001);
`endif
      end
      if (i == 1024) begin
        check("score_32", score, 8'd32);
        check("alive_1024", alive, 1'b1);
      end
    end
    check("score_sat", score, 8'd255);
    check("alive_8192", alive, 1'b1);
    for (int k = 0; k < 80 && alive; k++) do_tick();
    check("fall_dead", alive, 1'b0);
    check("dead_score_held", score, 8'd255);
    repeat (64) do_tick();
    pulse_flap(); do_tick();
    probe(66, 120, 3'b001, 1'b1, px); check("idle_again", px, 3'b110);
    check("idle_score_held", score, 8'd255);
    pulse_flap(); do_tick();
    check("refly_alive", alive, 1'b1);
    check("refly_score_clr", score, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flappy_bird_overlay.md
# flappy_bird_overlay

- Sits downstream of the scrolling procedural-space background generator and takes its 3-bit `rgb` output.
- Overlays the player bird sprite and runs per-frame flap/gravity physics.
- Detects collisions with the background mountain layer and keeps the score.
- Delivers the final pixel colour and re-aligned sync signals to the VGA pins.

## Interface
- `BIRD_X`, 64: fixed left column of the 8x8 sprite.
- `START_Y`, 120: bird top row in IDLE.
- `FLOOR_Y`, 232: bird top row at or beyond which the bird dies.
- `CEIL_Y`, 8: minimum bird top row (clamp).
- `FLAP_V`, 6: upward speed set by a flap (px/frame).
- `MAX_FALL`, 8: terminal downward speed (px/frame).
- `BIRD_COLOR`, 3'b110: sprite colour while alive.
- `DEAD_COLOR`, 3'b100: sprite colour in DEAD.
- `DEAD_FRAMES`, 64: frames DEAD ignores flap.
- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-low reset.
- `hpos` in 10: current pixel column from the sync generator.
- `vpos` in 10: current pixel row.
- `display_on` in 1: active video.
- `hsync_in`, `vsync_in` in 1 each: raw syncs.
- `bg_rgb` in 3: background colour for (`hpos`,`vpos`).
- `flap` in 1: asynchronous push-button, active-high.
- `rgb` out 3: composited colour, registered.
- `hsync`, `vsync` out 1 each: syncs delayed to match `rgb`.
- `score` out 8: frames-survived score.
- `alive` out 1: high in FLY.

## Operation
- **Frame tick:** asserted for one cycle when `hpos==0 && vpos==0`. All physics and state updates happen only on a tick.
- **Flap input path:**
  - `flap` passes through a 2-flop synchronizer, then a rising-edge detector.
  - An edge sets `flap_pending`. The next tick consumes and clears it.
  - Multiple edges between ticks count as one flap.
- **State machine:** IDLE, FLY, DEAD.
  - IDLE: `bird_y=START_Y`, `vel=0`. On a tick with `flap_pending`, go to FLY, set `vel=-FLAP_V`, clear `score`.
  - FLY, per tick, in this order:
    - `vel = flap_pending ? -FLAP_V : min(vel+1, MAX_FALL)`.
    - `bird_y = max(bird_y+vel, CEIL_Y)`.
    - If `hit` or new `bird_y >= FLOOR_Y`, go to DEAD and clear `dead_cnt`.
    - Otherwise, increment `frame_cnt[4:0]`; each wrap to 0 increments `score`, saturating at 255.
  - DEAD:
    - Position and score are frozen and `dead_cnt` increments per tick.
    - Flaps that arrive while `dead_cnt < DEAD_FRAMES` are discarded.
    - After that, a tick with `flap_pending` goes to IDLE (bird reset to `START_Y`, `vel=0`). `score` holds until the next FLY entry.
  - Death wins over a simultaneous flap on the same tick.
- **Arithmetic:**
  - `vel` is 6-bit signed.
  - `bird_y` is 10-bit unsigned, computed in 11-bit signed and clamped before truncation.
- **Sprite:** `dx=hpos-BIRD_X`, `dy=vpos-bird_y`.
  - Pixel hit when `0<=dx<8`, `0<=dy<8`, and bit `{dy[2:0],dx[2:0]}` of an internal 64-bit bitmap is 1.
  - Sprite is opaque and replaces `bg_rgb` with `BIRD_COLOR`/`DEAD_COLOR`.
  - Not drawn when `display_on` is 0.
- **Collision:**
  - `hit` is set when, in FLY, a sprite pixel coincides with `bg_rgb[1]==1` while `display_on`. `bg_rgb[1]` is the near-mountain bit.
  - `hit` is sampled and then cleared on the tick, so it covers the previous whole frame.
  - Star pixels that do not set bit 1 are harmless.
- **Output colour:** `rgb = display_on ? (sprite ? sprite_color : bg_rgb) : 0`.

## Timing
- `rgb`, `hsync`, `vsync` are registered with 1-cycle latency relative to `hpos`/`vpos`/`hsync_in`/`vsync_in`.
- Physics registers change in the cycle after the tick. The new position is visible from pixel (1,0) of the same frame; `CEIL_Y>=8` keeps row 0 sprite-free, so no tearing.
- Flap latency: edge → `flap_pending` takes 3 cycles (2 sync + 1 edge). It takes effect at the first tick after that.
- A mid-operation reset (`reset==0` at any clock edge) restores all reset values next cycle:
  - state IDLE, `bird_y=START_Y`, `vel=0`, `score=0`.
  - `frame_cnt=0`, `dead_cnt=0`, `hit=0`, `flap_pending=0`, sync flops 0.
  - outputs `rgb=0`, `hsync=0`, `vsync=0`, `alive=0`.

## Configuration
- `FLAPPY_SCORE_BAR_EN`:
  - Defined: when `display_on` and `vpos<4` and `hpos<{score,1'b0}`, `rgb=3'b111`, overriding background and sprite. This is a score bar, 2 px per point.
  - Undefined: no bar logic is built and `score` is only exported on the port.

## Test plan
- Reset with `reset=0` for 3 cycles → `rgb=0`, `alive=0`, `score=0`, `bird_y=120`, state IDLE. Then the sprite is drawn from column 64, rows 120-127, in colour 3'b110.
- Flap pulse in IDLE, then 1 tick → `alive=1`, `bird_y=114`. Over the next ticks without a flap, `vel` goes -5,-4,…; from `vel=8`, `bird_y` grows by 8 per frame.
- Two flap pulses between ticks → exactly one flap applied. A flap 2 cycles before a tick → applied at the following tick.
- FLY without flaps from `START_Y` → DEAD on the first tick with `bird_y>=232`, `rgb` sprite becomes 3'b100. A flap within 64 ticks is ignored; a flap afterwards returns to IDLE with `score` held.
- Force `bg_rgb=3'b010` over the sprite area during FLY → DEAD at the next tick, even with a simultaneous flap. `bg_rgb=3'b101` under the sprite → no death.
- 1024 FLY ticks → `score=32`. Preset `score=255` → stays 255. With `FLAPPY_SCORE_BAR_EN` and `score=10`: row 2, `hpos`=0..19 gives `rgb=7`, `hpos=20` gives background.
